// File: rtl/result_pipe.sv
// Result pipeline: carries register writes through DEPTH stages
// and forwards in-flight results to lookup ports.
module result_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_wreg,
    input  logic [ADDR_W-1:0]        in_wd,
    input  logic [DATA_W-1:0]        in_wdata,
    input  logic [DEPTH-1:0]         stall,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        fwd_hit,
    output logic [NUM_RD*DATA_W-1:0] fwd_data,
    output logic                     wb_wreg,
    output logic [ADDR_W-1:0]        wb_wd,
    output logic [DATA_W-1:0]        wb_wdata,
    output logic [31:0]              retire_cnt
);

    logic [DEPTH-1:0]  st_wreg;
    logic [ADDR_W-1:0] st_wd    [DEPTH];
    logic [DATA_W-1:0] st_wdata [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_wreg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                st_wd[k]    <= '0;
                st_wdata[k] <= '0;
            end
        end else if (flush) begin
            st_wreg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                st_wd[k]    <= '0;
                st_wdata[k] <= '0;
            end
        end else begin
            if (!stall[0]) begin
                st_wreg[0]  <= in_wreg;
                st_wd[0]    <= in_wd;
                st_wdata[0] <= in_wdata;
            end
            // A stalled upstream stage leaves a bubble behind a moving one.
            for (int k = 1; k < DEPTH; k++) begin
                if (!stall[k]) begin
                    if (stall[k-1]) begin
                        st_wreg[k]  <= 1'b0;
                        st_wd[k]    <= '0;
                        st_wdata[k] <= '0;
                    end else begin
                        st_wreg[k]  <= st_wreg[k-1];
                        st_wd[k]    <= st_wd[k-1];
                        st_wdata[k] <= st_wdata[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_wreg && !stall[DEPTH-1] && !flush) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign wb_wreg  = st_wreg[DEPTH-1];
    assign wb_wd    = st_wd[DEPTH-1];
    assign wb_wdata = st_wdata[DEPTH-1];

    genvar p;
    for (p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Scan oldest to youngest so the youngest match overrides.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (addr != '0) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (st_wreg[k] && st_wd[k] == addr) begin
                        hit  = 1'b1;
                        data = st_wdata[k];
                    end
                end
                if (in_wreg && in_wd == addr) begin
                    hit  = 1'b1;
                    data = in_wdata;
                end
            end
        end

        assign fwd_hit[p]                  = hit;
        assign fwd_data[p*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_result_pipe.sv
// Directed bench for result_pipe at default parameters
// (DEPTH=3, two lookup ports).
module tb_result_pipe;

    logic        clk;
    logic        rst;
    logic        in_wreg;
    logic [4:0]  in_wd;
    logic [31:0] in_wdata;
    logic [2:0]  stall;
    logic        flush;
    logic [9:0]  rd_addr;
    logic [1:0]  fwd_hit;
    logic [63:0] fwd_data;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic [31:0] retire_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    result_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_wreg    (in_wreg),
        .in_wd      (in_wd),
        .in_wdata   (in_wdata),
        .stall      (stall),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .wb_wreg    (wb_wreg),
        .wb_wd      (wb_wd),
        .wb_wdata   (wb_wdata),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] a,
                         input logic [31:0] d);
        in_wreg  = w;
        in_wd    = a;
        in_wdata = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0);
        stall   = 3'b000;
        flush   = 1'b0;
        rd_addr = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0);
        stall   = 3'b000;
        flush   = 1'b0;
        rd_addr = '0;
        #1;
        chk("rst_wb_wreg", 64'(wb_wreg), 64'd0);
        chk("rst_wb_wd", 64'(wb_wd), 64'd0);
        chk("rst_wb_wdata", 64'(wb_wdata), 64'd0);
        chk("rst_retire", 64'(retire_cnt), 64'd0);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        drive(1'b1, 5'd4, 32'h44);
        rd_addr = {5'd0, 5'd4};
        #1;
        chk("rst_in_hit", 64'(fwd_hit), 64'h1);
        chk("rst_in_data", fwd_data, 64'h44);
        tick();
        tick();
        drive(1'b0, 5'd0, 32'd0);
        rd_addr = '0;
        rst = 1'b0;

        // Plain flow
        drive(1'b1, 5'd5, 32'h11);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("flow_e2_wreg", 64'(wb_wreg), 64'd0);
        tick();
        chk("flow_wb", {31'd0, wb_wreg, 27'd0, wb_wd}, {31'd0, 1'b1, 27'd0, 5'd5});
        chk("flow_wdata", 64'(wb_wdata), 64'h11);
        chk("flow_e3_retire", 64'(retire_cnt), 64'd0);
        tick();
        chk("flow_retire", 64'(retire_cnt), 64'd1);
        chk("flow_e4_wreg", 64'(wb_wreg), 64'd0);

        // Bubble insertion
        do_reset();
        drive(1'b1, 5'd6, 32'h66);
        tick();
        drive(1'b1, 5'd7, 32'hAA);
        stall = 3'b001;
        tick();
        stall = 3'b000;
        drive(1'b0, 5'd0, 32'd0);
        rd_addr = {5'd0, 5'd6};
        #1;
        chk("bub_s0_held", fwd_data, 64'h66);
        drive(1'b1, 5'd7, 32'hAA);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        chk("bub_wb_bubble", 64'(wb_wreg), 64'd0);
        tick();
        chk("bub_wb_66", 64'(wb_wdata), 64'h66);
        tick();
        chk("bub_wb_aa", 64'(wb_wdata), 64'hAA);
        chk("bub_wb_wd", 64'(wb_wd), 64'd7);
        chk("bub_retire", 64'(retire_cnt), 64'd1);

        // Forwarding priority
        do_reset();
        drive(1'b1, 5'd3, 32'h33);
        tick();
        drive(1'b1, 5'd9, 32'h99);
        tick();
        drive(1'b1, 5'd3, 32'h30);
        tick();
        drive(1'b1, 5'd3, 32'h3F);
        rd_addr = {5'd9, 5'd3};
        #1;
        chk("pri_hit", 64'(fwd_hit), 64'h3);
        chk("pri_in", fwd_data, {32'h99, 32'h3F});
        in_wreg = 1'b0;
        #1;
        chk("pri_s0", fwd_data, {32'h99, 32'h30});
        stall = 3'b001;
        in_wreg = 1'b1;
        #1;
        chk("pri_in_stalled", fwd_data, {32'h99, 32'h3F});
        stall = 3'b000;
        drive(1'b0, 5'd0, 32'd0);
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("pri_s0_only", fwd_data, 64'h30);
        tick();
        tick();
        chk("pri_s2_oldest", fwd_data, 64'h30);
        tick();
        chk("pri_miss_hit", 64'(fwd_hit), 64'd0);
        chk("pri_miss_data", fwd_data, 64'd0);

        // Register zero never forwards
        do_reset();
        drive(1'b1, 5'd0, 32'hFF);
        tick();
        tick();
        tick();
        rd_addr = '0;
        #1;
        chk("zero_wb", 64'(wb_wdata), 64'hFF);
        chk("zero_hit", 64'(fwd_hit), 64'd0);
        chk("zero_data", fwd_data, 64'd0);

        // Partial stall, then flush under full stall
        do_reset();
        drive(1'b1, 5'd10, 32'h1);
        tick();
        drive(1'b1, 5'd11, 32'h2);
        tick();
        drive(1'b1, 5'd12, 32'h3);
        tick();
        chk("fl_wb_wreg", 64'(wb_wreg), 64'd1);
        drive(1'b1, 5'd13, 32'h4);
        stall = 3'b100;
        tick();
        drive(1'b0, 5'd0, 32'd0);
        rd_addr = {5'd12, 5'd11};
        #1;
        chk("hold_wb", 64'(wb_wdata), 64'h1);
        chk("hold_retire", 64'(retire_cnt), 64'd0);
        chk("hold_hit", 64'(fwd_hit), 64'h2);
        stall = 3'b111;
        flush = 1'b1;
        drive(1'b1, 5'd14, 32'h5);
        tick();
        flush = 1'b0;
        stall = 3'b000;
        drive(1'b0, 5'd0, 32'd0);
        rd_addr = {5'd13, 5'd10};
        #1;
        chk("fl_wb_wreg0", 64'(wb_wreg), 64'd0);
        chk("fl_hit", 64'(fwd_hit), 64'd0);
        chk("fl_retire", 64'(retire_cnt), 64'd0);

        // Asynchronous reset mid-operation
        do_reset();
        drive(1'b1, 5'd20, 32'h20);
        tick();
        drive(1'b1, 5'd21, 32'h21);
        tick();
        drive(1'b1, 5'd22, 32'h22);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("ar_pre_retire", 64'(retire_cnt), 64'd1);
        chk("ar_pre_wb", 64'(wb_wdata), 64'h21);
        rd_addr = {5'd0, 5'd22};
        #2;
        rst = 1'b1;
        #1;
        chk("ar_wb_wreg", 64'(wb_wreg), 64'd0);
        chk("ar_wb_wdata", 64'(wb_wdata), 64'd0);
        chk("ar_retire", 64'(retire_cnt), 64'd0);
        chk("ar_hit", 64'(fwd_hit), 64'd0);
        rst = 1'b0;
        drive(1'b1, 5'd5, 32'h55);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("ar_post_fwd", fwd_data, 64'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
